// File: rtl/irqsrcgate.sv
// Interrupt source conditioner: raw lines -> controller stb/rdy handshake, with per-line
// level/edge and polarity selection. Define IRQSRCGATE_SYNC_EN to add 2-flop input synchronizers.
module irqsrcgate #(
  parameter int ARCHBITSZ = 16,
  parameter int IRQCOUNT  = 1,
  parameter int CNTBITSZ  = 4
) (
  input  logic                                      rst_i,
  input  logic                                      clk_i,
  input  logic                                      wb_cyc_i,
  input  logic                                      wb_stb_i,
  input  logic                                      wb_we_i,
  input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]  wb_addr_i,
  input  logic [ARCHBITSZ/8-1:0]                    wb_sel_i,
  input  logic [ARCHBITSZ-1:0]                      wb_dat_i,
  output logic                                      wb_bsy_o,
  output logic                                      wb_ack_o,
  output logic [ARCHBITSZ-1:0]                      wb_dat_o,
  output logic [ARCHBITSZ-1:0]                      wb_mapsz_o,
  input  logic [IRQCOUNT-1:0]                       irq_i,
  output logic [IRQCOUNT-1:0]                       irq_stb_o,
  input  logic [IRQCOUNT-1:0]                       irq_rdy_i,
  output logic [2*IRQCOUNT-1:0]                     dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [CNTBITSZ-1:0] CNT_MAX = '1;
  localparam logic [CNTBITSZ-1:0] CNT_ONE = 1;

  // Bus request stage
  logic                 r_req;
  logic                 r_we;
  logic [1:0]           r_addr;
  logic [ARCHBITSZ-1:0] r_wdat;
  logic                 r_ack;
  logic [ARCHBITSZ-1:0] r_rdat;
  logic [ARCHBITSZ-1:0] w_rdata;

  logic [IRQCOUNT-1:0]  r_mode;
  logic [IRQCOUNT-1:0]  r_pol;
  logic [IRQCOUNT-1:0]  r_qp;
  logic [IRQCOUNT-1:0]  r_stb;
  logic [CNTBITSZ-1:0]  r_cnt [IRQCOUNT];
  logic [CNTBITSZ-1:0]  w_cnt_nxt [IRQCOUNT];
  state_t               r_state [IRQCOUNT];
  state_t               w_state_nxt [IRQCOUNT];

  logic [IRQCOUNT-1:0]  w_irq;
  logic [IRQCOUNT-1:0]  w_q;
  logic [IRQCOUNT-1:0]  w_rise;
  logic [IRQCOUNT-1:0]  w_dec;
  logic [IRQCOUNT-1:0]  w_ev;
  logic [IRQCOUNT-1:0]  w_cnt_clr;
  logic                 w_wr_mode;
  logic                 w_wr_pol;
  logic                 w_wr_clr;
  logic                 w_unused;

  assign wb_bsy_o    = 1'b0;
  assign wb_ack_o    = r_ack;
  assign wb_dat_o    = r_rdat;
  assign wb_mapsz_o  = ARCHBITSZ'(4 * (ARCHBITSZ / 8));
  assign irq_stb_o   = r_stb;
  assign w_unused    = ^{wb_sel_i, wb_addr_i, r_wdat};

`ifdef IRQSRCGATE_SYNC_EN
  logic [IRQCOUNT-1:0] r_sync1;
  logic [IRQCOUNT-1:0] r_sync2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq = r_sync2;
`else
  assign w_irq = irq_i;
`endif

  assign w_q    = w_irq ^ r_pol;
  assign w_rise = w_q & ~r_qp;

  assign w_wr_mode = r_req && r_we && (r_addr == 2'd0);
  assign w_wr_pol  = r_req && r_we && (r_addr == 2'd1);
  assign w_wr_clr  = r_req && r_we && (r_addr == 2'd3);

  // A MODE write clears counters of lines whose mode flips; CLR clears the written bits.
  assign w_cnt_clr = (w_wr_mode ? (r_mode ^ r_wdat[IRQCOUNT-1:0]) : '0)
                   | (w_wr_clr  ? r_wdat[IRQCOUNT-1:0] : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req  <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= 2'd0;
      r_wdat <= '0;
      r_ack  <= 1'b0;
      r_rdat <= '0;
      r_mode <= '0;
      r_pol  <= '0;
      r_qp   <= '0;
    end else begin
      r_req  <= wb_cyc_i && wb_stb_i;
      r_we   <= wb_we_i;
      r_addr <= wb_addr_i[1:0];
      r_wdat <= wb_dat_i;
      r_ack  <= r_req;
      r_rdat <= (r_req && !r_we) ? w_rdata : '0;
      if (w_wr_mode) r_mode <= r_wdat[IRQCOUNT-1:0];
      if (w_wr_pol)  r_pol  <= r_wdat[IRQCOUNT-1:0];
      r_qp   <= w_q;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (r_addr)
      2'd0:    w_rdata[IRQCOUNT-1:0] = r_mode;
      2'd1:    w_rdata[IRQCOUNT-1:0] = r_pol;
      2'd2:    w_rdata[IRQCOUNT-1:0] = w_ev;
      default: w_rdata = '0;
    endcase
  end

  // Counter: clear wins; a rise and an ACK entry in the same cycle cancel.
  always_comb begin
    for (int i = 0; i < IRQCOUNT; i++) begin
      w_dec[i]     = (r_state[i] == ST_REQ) && !irq_rdy_i[i];
      w_ev[i]      = r_mode[i] ? (r_cnt[i] != '0) : w_q[i];
      w_cnt_nxt[i] = r_cnt[i];
      if (w_cnt_clr[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_mode[i]) begin
        if (w_rise[i] && !w_dec[i] && (r_cnt[i] != CNT_MAX))
          w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
        else if (w_dec[i] && !w_rise[i] && (r_cnt[i] != '0))
          w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < IRQCOUNT; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_IDLE: if (w_ev[i] && irq_rdy_i[i]) w_state_nxt[i] = ST_REQ;
        ST_REQ:  if (!irq_rdy_i[i])           w_state_nxt[i] = ST_ACK;
        ST_ACK:  if (irq_rdy_i[i])            w_state_nxt[i] = ST_IDLE;
        default:                              w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < IRQCOUNT; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_stb <= '0;
    end else begin
      for (int i = 0; i < IRQCOUNT; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_stb[i]   <= (w_state_nxt[i] == ST_REQ);
      end
    end
  end

  always_comb begin
    dbg_state_o = '0;
    for (int i = 0; i < IRQCOUNT; i++)
      dbg_state_o[2*i +: 2] = r_state[i];
  end

endmodule

// File: tb/tb_irqsrcgate.sv
// Directed bench for irqsrcgate: 16-bit bus, two lines, 2-bit pending counters.
module tb_irqsrcgate;

  logic        clk;
  logic        rst;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [14:0] wb_addr;
  logic [1:0]  wb_sel;
  logic [15:0] wb_dat_w;
  logic        wb_bsy;
  logic        wb_ack;
  logic [15:0] wb_dat_r;
  logic [15:0] wb_mapsz;
  logic [1:0]  irq;
  logic [1:0]  irq_stb;
  logic [1:0]  irq_rdy;
  logic [3:0]  dbg_state;

  int n_cmp;
  int n_bad;
  int rise_cnt [2];
  logic [1:0] stb_prev;
  logic [15:0] rd;

  irqsrcgate #(.ARCHBITSZ(16), .IRQCOUNT(2), .CNTBITSZ(2)) dut (
    .rst_i(rst), .clk_i(clk),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_addr_i(wb_addr), .wb_sel_i(wb_sel), .wb_dat_i(wb_dat_w),
    .wb_bsy_o(wb_bsy), .wb_ack_o(wb_ack), .wb_dat_o(wb_dat_r), .wb_mapsz_o(wb_mapsz),
    .irq_i(irq), .irq_stb_o(irq_stb), .irq_rdy_i(irq_rdy),
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Count stb rising edges, sampled mid-cycle
  initial stb_prev = 2'b00;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (irq_stb[i] && !stb_prev[i]) rise_cnt[i]++;
    stb_prev = irq_stb;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [15:0] data);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_addr = 15'(addr); wb_dat_w = data;
    tick(1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    tick(1);
    chk_val("write_ack", 32'(wb_ack), 32'd1);
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [15:0] data);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
    wb_addr = 15'(addr);
    tick(1);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    tick(1);
    chk_val("read_ack", 32'(wb_ack), 32'd1);
    data = wb_dat_r;
  endtask

  task automatic pulse0();
    irq[0] = 1'b1;
    tick(1);
    irq[0] = 1'b0;
    tick(1);
  endtask

  // Wait (bounded) for a request, then complete one rdy low/high handshake
  task automatic handshake(input int line);
    int k;
    k = 0;
    while (!irq_stb[line] && k < 20) begin
      tick(1);
      k++;
    end
    if (!irq_stb[line]) chk_val("hs_wait_stb", 32'(irq_stb[line]), 32'd1);
    irq_rdy[line] = 1'b0;
    tick(1);
    chk_val("hs_drop", 32'(irq_stb[line]), 32'd0);
    irq_rdy[line] = 1'b1;
    tick(1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rise_cnt[0] = 0; rise_cnt[1] = 0;
    rst = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_addr = '0; wb_sel = 2'b11; wb_dat_w = '0;
    irq = 2'b00; irq_rdy = 2'b11;
    tick(2);
    chk_val("rst_stb", 32'(irq_stb), 32'd0);
    chk_val("rst_ack", 32'(wb_ack), 32'd0);
    chk_val("rst_dat", 32'(wb_dat_r), 32'd0);
    chk_val("rst_state", 32'(dbg_state), 32'd0);
    chk_val("mapsz", 32'(wb_mapsz), 32'd8);
    chk_val("bsy", 32'(wb_bsy), 32'd0);
    rst = 1'b0;
    tick(1);

    // Edge path on line 0
    bus_write(2'd0, 16'h0001);
    bus_read(2'd0, rd);
    chk_val("mode_rb", 32'(rd), 32'h1);
    irq[0] = 1'b1;
    tick(1);
    irq[0] = 1'b0;
    chk_val("edge_stb_e1", 32'(irq_stb[0]), 32'd0);
    tick(1);
    chk_val("edge_stb_e2", 32'(irq_stb[0]), 32'd1);
    irq_rdy[0] = 1'b0;
    tick(1);
    chk_val("edge_drop", 32'(irq_stb[0]), 32'd0);
    chk_val("edge_state_ack", 32'(dbg_state[1:0]), 32'd2);
    bus_read(2'd2, rd);
    chk_val("edge_pend0", 32'(rd), 32'h0);
    irq_rdy[0] = 1'b1;
    tick(3);
    chk_val("edge_idle_stb", 32'(irq_stb), 32'd0);

    // Coalescing: three pulses during one request
    rise_cnt[0] = 0;
    pulse0(); pulse0(); pulse0();
    chk_val("coal_stb", 32'(irq_stb[0]), 32'd1);
    bus_read(2'd2, rd);
    chk_val("coal_pend", 32'(rd), 32'h1);
    for (int h = 0; h < 3; h++) handshake(0);
    tick(5);
    chk_val("coal_rises", 32'(rise_cnt[0]), 32'd3);
    chk_val("coal_stb_end", 32'(irq_stb[0]), 32'd0);
    bus_read(2'd2, rd);
    chk_val("coal_pend_end", 32'(rd), 32'h0);

    // Saturation: 20 pulses with rdy low
    irq_rdy[0] = 1'b0;
    for (int p = 0; p < 20; p++) pulse0();
    chk_val("sat_no_stb", 32'(irq_stb[0]), 32'd0);
    bus_read(2'd2, rd);
    chk_val("sat_pend", 32'(rd), 32'h1);
    rise_cnt[0] = 0;
    irq_rdy[0] = 1'b1;
    for (int h = 0; h < 3; h++) handshake(0);
    tick(6);
    chk_val("sat_rises", 32'(rise_cnt[0]), 32'd3);
    chk_val("sat_stb_end", 32'(irq_stb[0]), 32'd0);

    // Level, active-low on line 1
    rise_cnt[1] = 0;
    bus_write(2'd1, 16'h0002);
    for (int h = 0; h < 2; h++) begin
      handshake(1);
      chk_val("lvl_gap", 32'(irq_stb[1]), 32'd0);
      tick(1);
      chk_val("lvl_rereq", 32'(irq_stb[1]), 32'd1);
    end
    irq[1] = 1'b1;
    handshake(1);
    tick(5);
    chk_val("lvl_stb_end", 32'(irq_stb[1]), 32'd0);
    chk_val("lvl_rises", 32'(rise_cnt[1]), 32'd3);
    bus_read(2'd2, rd);
    chk_val("lvl_pend", 32'(rd), 32'h0);

    // CLR during REQ
    rise_cnt[0] = 0;
    pulse0(); pulse0();
    bus_write(2'd3, 16'h0001);
    chk_val("clr_hold", 32'(irq_stb[0]), 32'd1);
    bus_read(2'd2, rd);
    chk_val("clr_pend", 32'(rd), 32'h0);
    chk_val("clr_hold2", 32'(irq_stb[0]), 32'd1);
    irq_rdy[0] = 1'b0;
    tick(1);
    chk_val("clr_drop", 32'(irq_stb[0]), 32'd0);
    irq_rdy[0] = 1'b1;
    tick(6);
    chk_val("clr_no_rereq", 32'(irq_stb[0]), 32'd0);
    chk_val("clr_rises", 32'(rise_cnt[0]), 32'd1);

    // MODE write clears only lines whose mode changes
    irq_rdy[0] = 1'b0;
    pulse0(); pulse0();
    bus_read(2'd2, rd);
    chk_val("mode_pend_pre", 32'(rd), 32'h1);
    bus_write(2'd0, 16'h0001);
    bus_read(2'd2, rd);
    chk_val("mode_same_keep", 32'(rd), 32'h1);
    bus_write(2'd0, 16'h0000);
    bus_write(2'd0, 16'h0001);
    bus_read(2'd2, rd);
    chk_val("mode_toggle_clr", 32'(rd), 32'h0);
    irq_rdy[0] = 1'b1;
    tick(4);
    chk_val("mode_no_req", 32'(irq_stb[0]), 32'd0);

    // Reset during REQ with a bus write in flight
    pulse0(); pulse0();
    chk_val("rst_pre_req", 32'(irq_stb[0]), 32'd1);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_addr = 15'd0; wb_dat_w = 16'h0003;
    tick(1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    rst = 1'b1;
    irq[1] = 1'b0;
    tick(1);
    chk_val("rst2_stb", 32'(irq_stb), 32'd0);
    chk_val("rst2_ack", 32'(wb_ack), 32'd0);
    chk_val("rst2_dat", 32'(wb_dat_r), 32'd0);
    chk_val("rst2_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick(4);
    chk_val("rst2_no_req", 32'(irq_stb), 32'd0);
    bus_read(2'd0, rd);
    chk_val("rst2_mode", 32'(rd), 32'h0);
    bus_read(2'd1, rd);
    chk_val("rst2_pol", 32'(rd), 32'h0);
    bus_read(2'd3, rd);
    chk_val("clr_reads_0", 32'(rd), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irqsrcgate.md
# irqsrcgate

Interrupt source conditioner sitting directly upstream of the interrupt controller's source inputs. It converts raw device interrupt lines into the controller's source handshake, where stb is raised to request and dropped as soon as rdy falls. Each line is software-configurable as level or edge and as active-high or active-low. In edge mode, pulses that arrive while a request is in flight are counted, so no pulse is lost. A small memory-mapped slave provides configuration and status.

## Interface
- ARCHBITSZ, 16: bus data width; one of 16, 32 or 64.
- IRQCOUNT, 1: number of interrupt lines; 1 ≤ IRQCOUNT ≤ ARCHBITSZ.
- CNTBITSZ, 4: width of the per-line edge pending counter; must be ≥ 1.

- rst_i  in  1: reset; synchronous, active-high.
- clk_i  in  1: single clock; every register updates on its rising edge.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each: slave bus request.
- wb_addr_i  in  ARCHBITSZ-clog2(ARCHBITSZ/8): word address; only bits [1:0] are decoded.
- wb_sel_i  in  ARCHBITSZ/8: byte selects; ignored, every access is a full word.
- wb_dat_i  in  ARCHBITSZ: write data.
- wb_bsy_o  out  1: tied to 0.
- wb_ack_o  out  1: access acknowledge.
- wb_dat_o  out  ARCHBITSZ: read data.
- wb_mapsz_o  out  ARCHBITSZ: constant 4*(ARCHBITSZ/8).
- irq_i  in  IRQCOUNT: raw device interrupt lines.
- irq_stb_o  out  IRQCOUNT: request to the controller's source stb inputs.
- irq_rdy_i  in  IRQCOUNT: the controller's source rdy outputs.

## Operation
- Register map, by word address:
  - 0 MODE, rw: bit i = 1 selects edge mode, 0 selects level mode.
  - 1 POL, rw: bit i = 1 marks line i active-low.
  - 2 PEND, ro: bit i = 1 when line i has a pending event (count > 0 in edge mode, qualified level = 1 in level mode).
  - 3 CLR, wo: each bit i written as 1 zeroes cnt[i].
  - Bits at or above IRQCOUNT read 0 and are ignored on write.
  - Reading CLR returns 0.
- Qualified input: q[i] = irq[i] ^ POL[i]. irq is irq_i, or its synchronized copy when IRQSRCGATE_SYNC_EN is defined. The previous value qp[i] is registered.
- Edge mode, on each clock edge:
  - cnt[i] += (q & !qp), and cnt[i] -= dec[i], where dec[i] is the ACK-entry event defined below.
  - An increment and a decrement in the same cycle cancel; cnt is unchanged.
  - Increment saturates at 2^CNTBITSZ-1. Decrement floors at 0.
- Event present: ev[i] = MODE[i] ? (cnt[i] != 0) : q[i].
- Per-line FSM, state held in 2 bits:
  - IDLE: stb=0. Moves to REQ when ev[i] && irq_rdy_i[i].
  - REQ: stb=1. Moves to ACK when irq_rdy_i[i] == 0; that transition is dec[i].
  - ACK: stb=0. Moves to IDLE when irq_rdy_i[i] == 1.
- irq_stb_o[i] = (state == REQ), registered. It never rises while irq_rdy_i[i] is 0.
- A level-mode line that is still asserted after the ACK→IDLE transition issues a new request.
- Writing MODE zeroes cnt of every line whose MODE bit changes. The FSM state is untouched.
- CLR zeroes cnt but never withdraws a request already in REQ. The decrement that follows then floors at 0.
- A CLR and an increment in the same cycle resolve to cnt = 0.

## Timing
- Reset values: irq_stb_o = 0, wb_ack_o = 0, wb_dat_o = 0; MODE, POL and all cnt = 0; all FSMs in IDLE; qp = 0 and all synchronizer flops = 0.
- Bus access:
  - The request is registered at edge N.
  - The write takes effect, or read data is loaded, at edge N+1, where wb_ack_o rises for one cycle.
  - Back-to-back accesses are accepted every cycle.
- Request latency, without sync: q rises before edge N → cnt is 1 after edge N (edge mode) → irq_stb_o is 1 after edge N+1.
- Drop latency: irq_rdy_i falls before edge M → irq_stb_o is 0 after edge M, a one-cycle reaction.
- Re-request: irq_rdy_i rises before edge K → state is IDLE after edge K → stb rises after K+1 if ev is still present. Minimum stb-low gap is 2 cycles.
- Reset asserted mid-handshake: stb is 0 after the reset edge and pending counts are discarded.

## Configuration
- IRQSRCGATE_SYNC_EN defined: each irq_i bit passes through a 2-flop synchronizer before polarity qualification, adding 2 cycles to the request latency. Asynchronous device lines are safe.
- Not defined: irq_i is used directly and must already be synchronous to clk_i.

## Test plan
- Edge path: MODE = 1. One-cycle pulse on irq_i[0] → cnt = 1, stb[0] rises 2 edges after the pulse. Drive rdy low → stb drops next edge, PEND[0] reads 0.
- Pulse coalescing: MODE = 1. Three pulses while in REQ → PEND stays 1. After three full rdy low/high handshakes, exactly three stb assertions have occurred and cnt = 0.
- Saturation: CNTBITSZ = 2. Twenty pulses with rdy held low → cnt = 3; exactly 3 requests follow.
- Level and polarity: POL[1] = 1, MODE[1] = 0, irq_i[1] held low → repeated requests with 2-cycle stb gaps. Set irq_i[1] high → no further requests once the current handshake completes.
- Counter clearing: write CLR = 1 in REQ → stb holds until rdy falls, then cnt = 0 and no re-request. A MODE write toggling bit 0 zeroes cnt[0].
- Reset: rst_i pulsed during REQ → stb = 0, MODE = 0, reads return 0, wb_ack_o = 0 on the next edge.
